// File: rtl/dequantizer_stream.sv
// Streaming per-channel dequantizer: Q7.8 activations minus a zero point, scaled by a
// per-channel inverse scale, rounded half toward +inf and saturated, over a three-stage pipeline.
module dequantizer_stream #(
    parameter int DATA_W     = 16,
    parameter int FRAC_W     = 8,
    parameter int SCALE_W    = 24,
    parameter int INV_FRAC_W = 16,
    parameter int OUT_W      = 24,
    parameter int OUT_FRAC_W = 16,
    parameter int NUM_CH     = 32,
    parameter int CH_W       = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_last,
    input  logic [DATA_W-1:0]  zero_point,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_last,
    input  logic               cfg_we,
    input  logic [CH_W-1:0]    cfg_addr,
    input  logic [SCALE_W-1:0] cfg_scale,
    input  logic               sat_clr,
    output logic [15:0]        sat_count
);

    localparam int C_W = DATA_W + 1;
    localparam int P_W = C_W + SCALE_W;
    localparam int R_W = P_W + 1;
    localparam int SH  = FRAC_W + INV_FRAC_W - OUT_FRAC_W;

    localparam logic signed [R_W-1:0] RND     = (SH > 0) ? (R_W'(1) << (SH - 1)) : '0;
    localparam logic signed [R_W-1:0] OUT_MAX = R_W'((longint'(1) << (OUT_W - 1)) - 1);
    localparam logic signed [R_W-1:0] OUT_MIN = R_W'(-(longint'(1) << (OUT_W - 1)));
    localparam logic [SCALE_W-1:0]    SCALE_ONE = SCALE_W'(longint'(1) << INV_FRAC_W);

    // Handshake: a beat moves on in_valid && in_ready, an output on out_valid && out_ready.
    // The only stall source is a held output; it freezes every stage, so outputs stay stable.
    logic stall;
    logic accept;
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready;

    logic [SCALE_W-1:0] scale_tab [NUM_CH];
    logic [CH_W-1:0]    ch;

    logic                      s1_valid;
    logic                      s1_last;
    logic signed [C_W-1:0]     s1_c;
    logic signed [SCALE_W-1:0] s1_s;
    logic                      s2_valid;
    logic                      s2_last;
    logic signed [P_W-1:0]     s2_p;

    logic signed [R_W-1:0] r_full;
    logic                  sat_hi;
    logic                  sat_lo;
    logic [OUT_W-1:0]      r_clamp;
    logic                  enter_sat;

    always_comb begin
        r_full  = (R_W'(s2_p) + RND) >>> SH;
        sat_hi  = r_full > OUT_MAX;
        sat_lo  = r_full < OUT_MIN;
        r_clamp = r_full[OUT_W-1:0];
        if (sat_hi) begin
            r_clamp = OUT_MAX[OUT_W-1:0];
        end else if (sat_lo) begin
            r_clamp = OUT_MIN[OUT_W-1:0];
        end
    end

    assign enter_sat = !stall && s2_valid && (sat_hi || sat_lo);

    // The S1 lookup samples the table before this edge's write lands, so a same-cycle write is not seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                scale_tab[i] <= SCALE_ONE;
            end
        end else if (cfg_we) begin
            scale_tab[cfg_addr] <= cfg_scale;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch <= '0;
        end else if (accept) begin
            if (in_last || ch == CH_W'(NUM_CH - 1)) begin
                ch <= '0;
            end else begin
                ch <= ch + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_c      <= '0;
            s1_s      <= '0;
            s2_valid  <= 1'b0;
            s2_last   <= 1'b0;
            s2_p      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (!stall) begin
            s1_valid  <= in_valid;
            s1_last   <= in_last;
            s1_c      <= C_W'($signed(in_data)) - C_W'($signed(zero_point));
            s1_s      <= scale_tab[ch];
            s2_valid  <= s1_valid;
            s2_last   <= s1_last;
            s2_p      <= P_W'(s1_c) * P_W'(s1_s);
            out_valid <= s2_valid;
            out_last  <= s2_last;
            out_data  <= r_clamp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (sat_clr) begin
            sat_count <= enter_sat ? 16'd1 : 16'd0;
        end else if (enter_sat && sat_count != 16'hFFFF) begin
            sat_count <= sat_count + 16'd1;
        end
    end

endmodule
